// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: plays words from a small pattern memory onto LEDS,
// one word per accepted tick, with one-shot or looping playback.
module led_pattern_sequencer #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    input  logic [AW-1:0]    end_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] LEDS,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_pc;
    logic [AW-1:0]    r_end;
    logic             r_loop;
    logic             r_pending;
    logic [WIDTH-1:0] r_leds;
    logic             r_done;
    logic             r_overrun;

    logic             w_run;
    logic             w_start;
    logic             w_step;
    logic             w_at_end;

    assign w_run    = (r_state == ST_RUN);
    assign w_start  = start && !stop;
    // A step needs the memory, so any write (or a control pulse) defers it.
    assign w_step   = w_run && !start && !stop && !wr_en && (tick || r_pending);
    assign w_at_end = (r_pc == r_end);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment first keeps this block from inferring a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_next_state = ST_RUN;
            ST_RUN: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                end else if (!start && w_step && w_at_end && !r_loop) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_RUN);
    end

    // NOTE: the pattern memory has no reset so it maps onto RAM and keeps
    // its contents across RESET.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pc      <= '0;
            r_end     <= '0;
            r_loop    <= 1'b0;
            r_pending <= 1'b0;
            r_leds    <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_run && stop) begin
                r_pending <= 1'b0;
            end else if (w_start) begin
                r_pc      <= '0;
                r_end     <= end_addr;
                r_loop    <= loop;
                r_pending <= 1'b0;
                r_overrun <= 1'b0;
            end else if (w_step) begin
                r_leds    <= r_mem[r_pc];
                r_pending <= 1'b0;
                if (tick && r_pending) r_overrun <= 1'b1;
                r_pc      <= w_at_end ? '0 : r_pc + 1'b1;
                r_done    <= w_at_end && !r_loop;
            end else if (w_run && tick) begin
                // Only reachable with wr_en high: hold the step or lose it.
                if (r_pending) r_overrun <= 1'b1;
                else           r_pending <= 1'b1;
            end
        end
    end

    assign LEDS    = r_leds;
    assign done    = r_done;
    assign overrun = r_overrun;

endmodule
